// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, FSM encoding and
// the bubble value of the control/tag bundle.
package exe_defs;

  localparam logic [3:0] ALUC_ADD  = 4'd0;
  localparam logic [3:0] ALUC_SUB  = 4'd1;
  localparam logic [3:0] ALUC_AND  = 4'd2;
  localparam logic [3:0] ALUC_OR   = 4'd3;
  localparam logic [3:0] ALUC_XOR  = 4'd4;
  localparam logic [3:0] ALUC_NOR  = 4'd5;
  localparam logic [3:0] ALUC_SLT  = 4'd6;
  localparam logic [3:0] ALUC_SLTU = 4'd7;
  localparam logic [3:0] ALUC_SLL  = 4'd8;
  localparam logic [3:0] ALUC_SRL  = 4'd9;
  localparam logic [3:0] ALUC_SRA  = 4'd10;
  localparam logic [3:0] ALUC_LUI  = 4'd11;
  localparam logic [3:0] ALUC_MUL  = 4'd12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic       branch;
    logic [3:0] ins_type;
    logic [3:0] ins_number;
  } ctl_t;

  localparam ctl_t CTL_BUBBLE = 12'h000;

endpackage

// File: rtl/exe_stage_seq_mul.sv
// Shift-add multiplier: one multiplier bit consumed per clock; the product
// settles once the shifted multiplier runs out of set bits.
module seq_mul #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            abort,
  output logic [XLEN-1:0] product
);

  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (abort) begin
      mcand_d  = {XLEN{1'b0}};
      mplier_d = {XLEN{1'b0}};
      acc_d    = {XLEN{1'b0}};
    end else if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = {XLEN{1'b0}};
    end else if (mplier_q != {XLEN{1'b0}}) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end else begin
        acc_d = acc_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= {XLEN{1'b0}};
      mplier_q <= {XLEN{1'b0}};
      acc_q    <= {XLEN{1'b0}};
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign product = acc_q;

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: ID/EXE register with stall/flush, single-cycle ALU,
// branch-target adder and an iterative multiplier that stalls the pipe.
module exe_stage
  import exe_defs::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            id_wreg,
  input  logic            id_m2reg,
  input  logic            id_wmem,
  input  logic            id_branch,
  input  logic [3:0]      id_aluc,
  input  logic            id_aluimm,
  input  logic            id_shift,
  input  logic [XLEN-1:0] id_inA,
  input  logic [XLEN-1:0] id_inB,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_destR,
  input  logic [3:0]      ID_ins_type,
  input  logic [3:0]      ID_ins_number,
  output logic            ex_wreg,
  output logic            ex_m2reg,
  output logic            ex_wmem,
  output logic            ex_branch,
  output logic [XLEN-1:0] ex_aluR,
  output logic [XLEN-1:0] ex_inB,
  output logic [4:0]      ex_destR,
  output logic [XLEN-1:0] ex_pc,
  output logic            ex_zero,
  output logic            ex_busy,
  output logic [3:0]      EXE_ins_type,
  output logic [3:0]      EXE_ins_number
);

  localparam int CW = $clog2(MUL_CYCLES);

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d;
  ctl_t            ctl_q, ctl_d, id_ctl_s, ex_ctl_s;
  logic [3:0]      aluc_q, aluc_d;
  logic [XLEN-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [XLEN-1:0] inb_q, inb_d, imm_q, imm_d, pc_q, pc_d;
  logic [4:0]      dest_q, dest_d;
  logic [XLEN-1:0] id_op_a_s, id_op_b_s, alu_r_s, product_s;
  logic            mul_start_s, mul_abort_s, busy_s;

  assign id_ctl_s  = {id_wreg, id_m2reg, id_wmem, id_branch, ID_ins_type, ID_ins_number};
  assign id_op_a_s = id_shift  ? {{(XLEN-5){1'b0}}, id_imm[10:6]} : id_inA;
  assign id_op_b_s = id_aluimm ? id_imm : id_inB;

  // flush wins over everything, including an in-flight multiply
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    ctl_d       = ctl_q;
    aluc_d      = aluc_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    inb_d       = inb_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    dest_d      = dest_q;
    mul_start_s = 1'b0;
    mul_abort_s = 1'b0;
    if (flush) begin
      state_d     = ST_IDLE;
      cnt_d       = {CW{1'b0}};
      valid_d     = 1'b0;
      ctl_d       = CTL_BUBBLE;
      aluc_d      = ALUC_ADD;
      op_a_d      = {XLEN{1'b0}};
      op_b_d      = {XLEN{1'b0}};
      inb_d       = {XLEN{1'b0}};
      imm_d       = {XLEN{1'b0}};
      pc_d        = {XLEN{1'b0}};
      dest_d      = 5'd0;
      mul_abort_s = 1'b1;
    end else if (state_q == ST_RUN) begin
      if (cnt_q == {CW{1'b0}}) begin
        state_d = ST_DONE;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end else begin
      valid_d = 1'b1;
      ctl_d   = id_ctl_s;
      aluc_d  = id_aluc;
      op_a_d  = id_op_a_s;
      op_b_d  = id_op_b_s;
      inb_d   = id_inB;
      imm_d   = id_imm;
      pc_d    = id_pc;
      dest_d  = id_destR;
      if (id_aluc == ALUC_MUL) begin
        state_d     = ST_RUN;
        cnt_d       = CW'(MUL_CYCLES - 1);
        mul_start_s = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      valid_q <= 1'b0;
      ctl_q   <= CTL_BUBBLE;
      aluc_q  <= ALUC_ADD;
      op_a_q  <= {XLEN{1'b0}};
      op_b_q  <= {XLEN{1'b0}};
      inb_q   <= {XLEN{1'b0}};
      imm_q   <= {XLEN{1'b0}};
      pc_q    <= {XLEN{1'b0}};
      dest_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ctl_q   <= ctl_d;
      aluc_q  <= aluc_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      inb_q   <= inb_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      dest_q  <= dest_d;
    end
  end

  seq_mul #(.XLEN(XLEN)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start_s),
    .a       (id_op_a_s),
    .b       (id_op_b_s),
    .abort   (mul_abort_s),
    .product (product_s)
  );

  always_comb begin
    alu_r_s = {XLEN{1'b0}};
    case (aluc_q)
      ALUC_ADD:  alu_r_s = op_a_q + op_b_q;
      ALUC_SUB:  alu_r_s = op_a_q - op_b_q;
      ALUC_AND:  alu_r_s = op_a_q & op_b_q;
      ALUC_OR:   alu_r_s = op_a_q | op_b_q;
      ALUC_XOR:  alu_r_s = op_a_q ^ op_b_q;
      ALUC_NOR:  alu_r_s = ~(op_a_q | op_b_q);
      ALUC_SLT:  alu_r_s = {{(XLEN-1){1'b0}}, ($signed(op_a_q) < $signed(op_b_q))};
      ALUC_SLTU: alu_r_s = {{(XLEN-1){1'b0}}, (op_a_q < op_b_q)};
      ALUC_SLL:  alu_r_s = op_b_q << op_a_q[4:0];
      ALUC_SRL:  alu_r_s = op_b_q >> op_a_q[4:0];
      ALUC_SRA:  alu_r_s = XLEN'($signed(op_b_q) >>> op_a_q[4:0]);
      ALUC_LUI:  alu_r_s = op_b_q << 5'd16;
      ALUC_MUL:  alu_r_s = product_s;
      default:   alu_r_s = {XLEN{1'b0}};
    endcase
  end

  // Moore busy: a pure decode of the state register
  assign busy_s   = (state_q == ST_RUN);
  assign ex_ctl_s = busy_s ? CTL_BUBBLE : ctl_q;

  assign ex_busy        = busy_s;
  assign ex_wreg        = ex_ctl_s.wreg;
  assign ex_m2reg       = ex_ctl_s.m2reg;
  assign ex_wmem        = ex_ctl_s.wmem;
  assign ex_branch      = ex_ctl_s.branch;
  assign EXE_ins_type   = ex_ctl_s.ins_type;
  assign EXE_ins_number = ex_ctl_s.ins_number;
  assign ex_aluR        = busy_s ? {XLEN{1'b0}} : alu_r_s;
  assign ex_zero        = valid_q && !busy_s && (alu_r_s == {XLEN{1'b0}});
  assign ex_inB         = inb_q;
  assign ex_destR       = dest_q;
  assign ex_pc          = pc_q + (imm_q << 2);

endmodule

// File: tb/tb_exe_stage.sv
// Randomized and directed bench for exe_stage against a cycle-count
// reference model of the stage's capture/stall/flush behaviour.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic        id_wreg, id_m2reg, id_wmem, id_branch, id_aluimm, id_shift;
  logic [3:0]  id_aluc, ID_ins_type, ID_ins_number;
  logic [31:0] id_inA, id_inB, id_imm, id_pc;
  logic [4:0]  id_destR;
  logic        ex_wreg, ex_m2reg, ex_wmem, ex_branch, ex_zero, ex_busy;
  logic [31:0] ex_aluR, ex_inB, ex_pc;
  logic [4:0]  ex_destR;
  logic [3:0]  EXE_ins_type, EXE_ins_number;

  int total = 0;
  int bad   = 0;

  // reference model: what the stage currently holds and how many stall cycles remain
  int          m_left;
  logic        m_valid, m_known;
  logic        m_wreg, m_m2reg, m_wmem, m_branch;
  logic [3:0]  m_type, m_num, m_aluc;
  logic [31:0] m_a, m_b, m_inb, m_imm, m_pc;
  logic [4:0]  m_dest;

  exe_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem), .id_branch(id_branch),
    .id_aluc(id_aluc), .id_aluimm(id_aluimm), .id_shift(id_shift),
    .id_inA(id_inA), .id_inB(id_inB), .id_imm(id_imm), .id_pc(id_pc),
    .id_destR(id_destR), .ID_ins_type(ID_ins_type), .ID_ins_number(ID_ins_number),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem), .ex_branch(ex_branch),
    .ex_aluR(ex_aluR), .ex_inB(ex_inB), .ex_destR(ex_destR), .ex_pc(ex_pc),
    .ex_zero(ex_zero), .ex_busy(ex_busy),
    .EXE_ins_type(EXE_ins_type), .EXE_ins_number(EXE_ins_number)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sb;
    sb = b;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return b << a[4:0];
      4'd9:  return b >> a[4:0];
      4'd10: return 32'(sb >>> a[4:0]);
      4'd11: return b << 16;
      4'd12: return 32'(64'(a) * 64'(b));
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_left = 0; m_valid = 1'b0; m_known = 1'b1;
    {m_wreg, m_m2reg, m_wmem, m_branch} = 4'h0;
    m_type = 4'h0; m_num = 4'h0; m_aluc = 4'h0;
    m_a = 32'h0; m_b = 32'h0; m_inb = 32'h0; m_imm = 32'h0; m_pc = 32'h0; m_dest = 5'd0;
  endtask

  task automatic model_update();
    if (flush) begin
      m_left = 0; m_valid = 1'b0; m_known = 1'b0;
      {m_wreg, m_m2reg, m_wmem, m_branch} = 4'h0;
      m_type = 4'h0; m_num = 4'h0;
    end else if (m_left > 0) begin
      m_left--;
    end else begin
      m_valid = 1'b1; m_known = 1'b1;
      {m_wreg, m_m2reg, m_wmem, m_branch} = {id_wreg, id_m2reg, id_wmem, id_branch};
      m_type = ID_ins_type; m_num = ID_ins_number; m_aluc = id_aluc;
      m_a = id_shift ? {27'd0, id_imm[10:6]} : id_inA;
      m_b = id_aluimm ? id_imm : id_inB;
      m_inb = id_inB; m_imm = id_imm; m_pc = id_pc; m_dest = id_destR;
      m_left = (id_aluc == 4'd12) ? 32 : 0;
    end
  endtask

  task automatic compare();
    logic        eb, show;
    logic [31:0] res;
    eb   = (m_left > 0);
    show = !eb && m_valid;
    res  = ref_alu(m_aluc, m_a, m_b);
    check_eq("busy",   32'(ex_busy),   32'(eb));
    check_eq("wreg",   32'(ex_wreg),   32'(show & m_wreg));
    check_eq("m2reg",  32'(ex_m2reg),  32'(show & m_m2reg));
    check_eq("wmem",   32'(ex_wmem),   32'(show & m_wmem));
    check_eq("branch", 32'(ex_branch), 32'(show & m_branch));
    check_eq("type",   32'(EXE_ins_type),   show ? 32'(m_type) : 32'd0);
    check_eq("number", 32'(EXE_ins_number), show ? 32'(m_num)  : 32'd0);
    if (m_known) begin
      check_eq("pc",   ex_pc, m_pc + m_imm * 32'd4);
      check_eq("inB",  ex_inB, m_inb);
      check_eq("dest", 32'(ex_destR), 32'(m_dest));
      if (!eb) begin
        check_eq("aluR", ex_aluR, res);
        check_eq("zero", 32'(ex_zero), 32'(m_valid && (res == 32'd0)));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [31:0] pc, input logic wr,
                           input logic br, input logic alui, input logic sh);
    id_aluc = op; id_inA = a; id_inB = b; id_imm = imm; id_pc = pc;
    id_wreg = wr; id_branch = br; id_m2reg = 1'b0; id_wmem = 1'b0;
    id_aluimm = alui; id_shift = sh; id_destR = 5'd3;
    ID_ins_type = 4'h5; ID_ins_number = ID_ins_number + 4'd1;
  endtask

  initial begin
    int nb;
    rst_n = 1'b0; flush = 1'b0; ID_ins_number = 4'h0;
    set_instr(4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compare();
    check_eq("rst_aluR", ex_aluR, 32'd0);
    check_eq("rst_zero", 32'(ex_zero), 32'd0);

    set_instr(4'd0, 32'd5, 32'hFFFFFFFF, 32'd0, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    check_eq("add_res", ex_aluR, 32'd4);
    check_eq("add_wreg", 32'(ex_wreg), 32'd1);

    set_instr(4'd1, 32'd7, 32'd7, 32'hFFFFFFFE, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle();
    check_eq("beq_zero", 32'(ex_zero), 32'd1);
    check_eq("beq_pc", ex_pc, 32'h000000F8);

    set_instr(4'd10, 32'd0, 32'h80000000, 32'h00000100, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle();
    check_eq("sra_res", ex_aluR, 32'hF8000000);

    set_instr(4'd12, 32'h00010003, 32'h00020005, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    nb = ex_busy ? 1 : 0;
    set_instr(4'd0, 32'd10, 32'd20, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40 && ex_busy; i++) begin
      cycle();
      if (ex_busy) nb++;
    end
    check_eq("mul_busy_len", 32'(nb), 32'd32);
    check_eq("mul_prod", ex_aluR, 32'h000B000F);
    check_eq("mul_wreg", 32'(ex_wreg), 32'd1);
    cycle();
    check_eq("add_after_mul", ex_aluR, 32'd30);

    set_instr(4'd12, 32'd3, 32'd7, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    set_instr(4'd0, 32'd1, 32'd2, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (8) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check_eq("flush_busy", 32'(ex_busy), 32'd0);
    check_eq("flush_wreg", 32'(ex_wreg), 32'd0);
    cycle();
    check_eq("post_flush_add", ex_aluR, 32'd3);

    set_instr(4'd12, 32'd9, 32'd9, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    repeat (5) cycle();
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(ex_busy), 32'd0);
    check_eq("arst_aluR", ex_aluR, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    compare();
    set_instr(4'd3, 32'hF0, 32'h0F, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    check_eq("post_rst_or", ex_aluR, 32'hFF);

    for (int n = 0; n < 400; n++) begin
      id_aluc = ($urandom_range(0, 5) == 0) ? 4'd12 : 4'($urandom_range(0, 15));
      id_inA = $urandom; id_inB = ($urandom_range(0, 3) == 0) ? id_inA : $urandom;
      id_imm = $urandom; id_pc = $urandom; id_destR = 5'($urandom);
      {id_wreg, id_m2reg, id_wmem, id_branch, id_aluimm, id_shift} = 6'($urandom);
      ID_ins_type = 4'($urandom); ID_ins_number = 4'($urandom);
      flush = ($urandom_range(0, 15) == 0);
      cycle();
    end
    flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage pipelined MIPS CPU. It sits directly upstream of the memory stage and produces the ex_* bundle that stage latches every clock.
- Contains the ID/EXE pipeline register with stall and flush, the single-cycle ALU, and the branch-target adder.
- Contains an iterative 32-cycle multiplier. While the multiplier runs, the stage stalls upstream and emits bubbles downstream.

Parameters:
- XLEN, 32, datapath width
- MUL_CYCLES, 32, multiplier iterations (one product bit per cycle)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  squash the instruction entering EXE
- id_wreg  in  1  register write enable
- id_m2reg  in  1  write-back selects memory data
- id_wmem  in  1  data memory write enable
- id_branch  in  1  conditional branch (beq)
- id_aluc  in  4  ALU operation code
- id_aluimm  in  1  operand B = id_imm
- id_shift  in  1  operand A = id_imm[10:6] zero-extended
- id_inA  in  32  rs value
- id_inB  in  32  rt value
- id_imm  in  32  sign/zero-extended immediate
- id_pc  in  32  PC+4 of the instruction
- id_destR  in  5  destination register
- ID_ins_type  in  4  instruction-tracking type tag
- ID_ins_number  in  4  instruction-tracking sequence tag
- ex_wreg, ex_m2reg, ex_wmem, ex_branch  out  1 each  registered controls, gated to 0 during bubbles
- ex_aluR  out  32  ALU or multiplier result
- ex_inB  out  32  rt value (store data)
- ex_destR  out  5  destination register
- ex_pc  out  32  branch target = pc4 + (imm << 2), mod 2^32
- ex_zero  out  1  ex_aluR == 0
- ex_busy  out  1  stall request to IF/ID
- EXE_ins_type, EXE_ins_number  out  4 each  tracking tags

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All ID/EXE fields clear to 0 and the FSM goes to IDLE.
  - Every output reads 0, including ex_busy.
  - Reset asserted mid-multiply aborts the multiply with no residue.
- Capture: on a rising edge with ex_busy=0, the ID/EXE register loads all id_* inputs and the tracking tags.
  - With flush=1, it loads a bubble instead: controls=0, tags=0, data don't-care.
  - flush overrides ex_busy.
- Operand A: shamt when id_shift=1, otherwise inA.
- Operand B: imm when id_aluimm=1, otherwise inB.
- ALU operations (combinational, zero extra latency):
  - ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5.
  - SLT 6 (signed), SLTU 7: result 1/0.
  - SLL 8, SRL 9, SRA 10: shift B by A[4:0].
  - LUI 11: B << 16.
  - MUL 12: low 32 bits of A*B.
  - Codes 13-15: result 0.
  - Arithmetic wraps; no overflow trap.
- FSM states IDLE, RUN, DONE:
  - IDLE→RUN when an instruction with aluc=MUL is captured. The counter loads MUL_CYCLES-1 and the sub-module is started.
  - RUN: ex_busy=1 and the counter decrements each cycle. Outputs present a bubble: ex_wreg/m2reg/wmem/branch=0, tags=0.
  - RUN→DONE when the counter reaches 0.
  - DONE lasts one cycle: ex_busy=0, real controls/tags appear, ex_aluR=product, and the next instruction is captured at the end of the cycle.
  - DONE→RUN if that next instruction is MUL, otherwise DONE→IDLE.
  - flush during RUN: abort to IDLE and load a bubble.
- Latency:
  - Non-MUL instructions: outputs valid the cycle after capture.
  - MUL: 33 cycles in EXE (32 busy plus 1 DONE).
- ex_busy is a decoded Moore output: it depends only on state and has no combinational path from inputs.

Decomposition:
- Package exe_defs holds:
  - ALUC_* codes (4-bit)
  - FSM state encoding (2-bit)
  - the bubble constant for the control/tag bundle
- One sub-module, seq_mul: a shift-add multiplier.
  - Ports: clk, rst_n, start, a, b, abort, product.
  - Advances one bit per cycle.

Test Plan:
1. Reset released, no input: all outputs 0; ex_busy=0.
2. ADD, inA=5, inB=0xFFFFFFFF, wreg=1: the next cycle gives ex_aluR=4, ex_zero=0, ex_wreg=1, with tags passed through.
3. BEQ SUB, inA=inB=7, pc4=0x100, imm=0xFFFFFFFE, branch=1: ex_zero=1, ex_branch=1, ex_pc=0x000000F8.
4. SRA with shift=1, imm[10:6]=4, inB=0x80000000: ex_aluR=0xF8000000.
5. MUL 0x00010003 × 0x00020005, then ADD queued:
   - ex_busy=1 for 32 cycles with bubble outputs.
   - The DONE cycle gives ex_aluR=0x000B000F and wreg=1.
   - The ADD is captured at the end of DONE and its result appears on the next cycle.
6. Flush asserted on cycle 10 of a MUL: return to IDLE, ex_busy=0 the next cycle, bubble outputs, no product emitted. rst_n pulsed mid-MUL gives the same recovery.
